gbt_rx_frameclk_dps_ctrl: RTL and testbench
===========================================

// Module: gbt_rx_frameclk_dps_ctrl
// PURPOSE
// - Multi-counter dynamic-phase-shift (DPS) sequencer for the GBT RX frame-clock phase-aligner PLL.
// - Accepts "shift counter C<n> by N steps up/down" requests and drives the PLL phase_en/updn/cntsel/phase_done handshake one step at a time.
// - Tracks each counter's accumulated phase position modulo one output period.
// - Reports completion, timeout and unlock events to the phase-aligner FSM above it.
// PARAMETERS
// - NUM_CNT         1     number of PLL C counters under control (1..18)
// - STEP_W          8     width of req_steps (max steps per request = 2**STEP_W-1)
// - STEPS_PER_PER   144   DPS steps per output-clock period (720 MHz VCO, 1/8 VCO step, /18) = position modulus
// - PE_WIDTH        2     phase_en high time in scanclk cycles (>=1)
// - SETTLE_CYC      4     idle cycles after each phase_done before next step (>=0)
// - TIMEOUT_CYC     1023  max cycles waited in either phase_done wait state
// PORTS
// - scanclk        in   1                  DPS clock; all logic on rising edge
// - rst            in   1                  synchronous, active-high reset
// - pll_locked     in   1                  PLL lock, synchronous to scanclk
// - req_valid      in   1                  request strobe
// - req_ready      out  1                  high in IDLE with pll_locked=1
// - req_cnt        in   5                  target C-counter index
// - req_updn       in   1                  1 = shift later (up), 0 = earlier (down)
// - req_steps      in   STEP_W             number of steps
// - pll_phase_en   out  1                  to PLL phase_en
// - pll_updn       out  1                  to PLL updn
// - pll_cntsel     out  5                  to PLL cntsel
// - pll_phase_done in   1                  from PLL phase_done (active-low busy)
// - busy           out  1                  high in any state except IDLE
// - done           out  1                  1-cycle pulse: request fully completed
// - err_timeout    out  1                  1-cycle pulse: phase_done handshake timed out
// - err_unlock     out  1                  1-cycle pulse: lock lost mid-request
// - err_range      out  1                  1-cycle pulse: req_cnt >= NUM_CNT, request dropped
// - steps_done     out  STEP_W             steps completed in current or last request
// - phase_pos      out  NUM_CNT*POS_W      per-counter position; POS_W = clog2(STEPS_PER_PER)
// BEHAVIOUR
// - Reset:
//   - all outputs 0 except req_ready = pll_locked;
//   - all phase_pos = 0; FSM in IDLE.
// - Accept: req_valid & req_ready at cycle T latches cnt/updn/steps.
//   - pll_cntsel/pll_updn are valid from T+1 and stable until return to IDLE.
// - FSM:
//   - IDLE --accept--> PULSE:
//     - steps = 0 -> DONE instead;
//     - bad cnt -> err_range pulse at T+1, stay IDLE.
//   - PULSE: pll_phase_en = 1 for PE_WIDTH cycles (first at T+1) -> WAIT_LO.
//   - WAIT_LO: wait for registered phase_done = 0 -> WAIT_HI.
//   - WAIT_HI: wait for registered phase_done = 1.
//     - On exit: steps_done += 1; phase_pos[cnt] updated; -> SETTLE.
//   - SETTLE: SETTLE_CYC cycles, then:
//     - steps_done == req_steps -> DONE;
//     - else -> PULSE.
//   - DONE: done = 1 for one cycle -> IDLE.
// - Position update (modulo wrap):
//   - up: pos = (pos == STEPS_PER_PER-1) ? 0 : pos+1;
//   - down: pos = (pos == 0) ? STEPS_PER_PER-1 : pos-1.
// - Timeout: counter reloads on entry to WAIT_LO and WAIT_HI.
//   - Reaching TIMEOUT_CYC -> err_timeout pulse, -> IDLE; the pending step is not counted.
// - Unlock: pll_locked = 0 in any non-IDLE state -> err_unlock pulse next cycle.
//   - phase_en is forced 0 immediately (combinational gate); -> IDLE; positions keep last completed step.
// - Precedence when events coincide in one cycle: rst > unlock > timeout > normal transition.
// - req_valid outside IDLE is ignored; no queuing.
// - rst mid-request: positions cleared to 0.
//   - Upper layer must re-run alignment; no partial phase_en pulse may follow rst.
// STRUCTURE
// - Package gbt_dps_pkg: state enum (IDLE, PULSE, WAIT_LO, WAIT_HI, SETTLE, DONE), POS_W function, CNTSEL_W = 5.
// - Sub-module gbt_dps_step_timer: loadable down-counter shared by PULSE/SETTLE/timeout; provides a zero flag.
// - Top holds FSM, request latch, step counter, phase_pos register array.
// TESTING
// - Single step: locked, cnt=0, up, steps=1; PLL model drops done 2 cyc after phase_en, raises it 5 cyc later.
//   -> phase_en high at T+1..T+2; done pulse once; pos[0] = 1; steps_done = 1.
// - Wrap: pos[0] = 143, up, steps=3 -> pos[0] = 2.
//   - Then down, steps=3 -> 143; exactly 3 phase_en pulses each time.
// - Zero/range: steps=0 -> done at T+1, no phase_en.
//   - NUM_CNT=2, cnt=5 -> err_range at T+1, busy stays 0.
// - Timeout: PLL model never lowers phase_done -> err_timeout at TIMEOUT_CYC+PE_WIDTH+1 after accept.
//   - pos unchanged; req_ready = 1 next cycle.
// - Unlock: drop pll_locked during step 4 of 10 -> phase_en = 0 same cycle; err_unlock next cycle.
//   - steps_done = 3; pos advanced by 3.
// - Reset mid-request (step 2 WAIT_HI) -> next cycle all outputs 0, all pos = 0, no further phase_en.

Source files
------------

// File: rtl/gbt_dps_pkg.sv
// Shared types and helpers for the GBT RX frame-clock dynamic-phase-shift sequencer.
package gbt_dps_pkg;
   localparam int CNTSEL_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      PULSE,
      WAIT_LO,
      WAIT_HI,
      SETTLE,
      DONE
   } dps_state_e;

   function automatic int pos_w(input int steps_per_per);
      return (steps_per_per > 1) ? $clog2(steps_per_per) : 1;
   endfunction
endpackage

// File: rtl/gbt_dps_step_timer.sv
// Loadable down-counter that stops at zero; one instance serves the phase_en width,
// settle delay and handshake timeout since only one of them is live per state.
module gbt_dps_step_timer #(
   parameter int W = 10
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/gbt_rx_frameclk_dps_ctrl.sv
// DPS sequencer: walks the PLL phase_en/phase_done handshake one step at a time and
// tracks each C counter's phase position modulo one output period.
module gbt_rx_frameclk_dps_ctrl
   import gbt_dps_pkg::*;
#(
   parameter int NUM_CNT       = 1,
   parameter int STEP_W        = 8,
   parameter int STEPS_PER_PER = 144,
   parameter int PE_WIDTH      = 2,
   parameter int SETTLE_CYC    = 4,
   parameter int TIMEOUT_CYC   = 1023,
   localparam int POS_W        = pos_w(STEPS_PER_PER)
) (
   input  logic                     scanclk_i,
   input  logic                     rst_i,
   input  logic                     pll_locked_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [CNTSEL_W-1:0]      req_cnt_i,
   input  logic                     req_updn_i,
   input  logic [STEP_W-1:0]        req_steps_i,
   output logic                     pll_phase_en_o,
   output logic                     pll_updn_o,
   output logic [CNTSEL_W-1:0]      pll_cntsel_o,
   input  logic                     pll_phase_done_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_timeout_o,
   output logic                     err_unlock_o,
   output logic                     err_range_o,
   output logic [STEP_W-1:0]        steps_done_o,
   output logic [NUM_CNT*POS_W-1:0] phase_pos_o
);
   localparam int TMR_MAX = (TIMEOUT_CYC > PE_WIDTH)
                          ? ((TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC)
                          : ((PE_WIDTH > SETTLE_CYC) ? PE_WIDTH : SETTLE_CYC);
   localparam int TMR_W = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] PE_LD = TMR_W'(PE_WIDTH - 1);
   localparam logic [TMR_W-1:0] ST_LD = TMR_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
   localparam logic [TMR_W-1:0] TO_LD = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [POS_W-1:0] POS_MAX = POS_W'(STEPS_PER_PER - 1);
   localparam logic [CNTSEL_W:0] NUM_CNT_L = (CNTSEL_W + 1)'(NUM_CNT);

   dps_state_e                     state_q, state_d;
   logic [CNTSEL_W-1:0]            cnt_q, cnt_d;
   logic                           updn_q, updn_d;
   logic [STEP_W-1:0]              steps_q, steps_d;
   logic [STEP_W-1:0]              sdone_q, sdone_d;
   logic [NUM_CNT-1:0][POS_W-1:0]  pos_q, pos_d;
   logic                           pd_q;
   logic                           err_to_q, err_to_d, err_ul_q, err_ul_d, err_rg_q, err_rg_d;
   logic                           tmr_ld, tmr_zero;
   logic [TMR_W-1:0]               tmr_val;
   logic                           accept;

   assign accept = req_valid_i & req_ready_o;

   gbt_dps_step_timer #(.W(TMR_W)) u_timer (
      .clk_i      (scanclk_i),
      .rst_i      (rst_i),
      .load_i     (tmr_ld),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      updn_d   = updn_q;
      steps_d  = steps_q;
      sdone_d  = sdone_q;
      pos_d    = pos_q;
      err_to_d = 1'b0;
      err_ul_d = 1'b0;
      err_rg_d = 1'b0;
      tmr_ld   = 1'b0;
      tmr_val  = PE_LD;
      // Lock loss outranks every other event once a request is in flight.
      if (state_q != IDLE && !pll_locked_i) begin
         err_ul_d = 1'b1;
         state_d  = IDLE;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               if ({1'b0, req_cnt_i} >= NUM_CNT_L) begin
                  err_rg_d = 1'b1;
               end else begin
                  cnt_d   = req_cnt_i;
                  updn_d  = req_updn_i;
                  steps_d = req_steps_i;
                  sdone_d = '0;
                  if (req_steps_i == '0) begin
                     state_d = DONE;
                  end else begin
                     state_d = PULSE;
                     tmr_ld  = 1'b1;
                  end
               end
            end
            PULSE: if (tmr_zero) begin
               state_d = WAIT_LO;
               tmr_ld  = 1'b1;
               tmr_val = TO_LD;
            end
            WAIT_LO: begin
               if (tmr_zero) begin
                  err_to_d = 1'b1;
                  state_d  = IDLE;
               end else if (!pd_q) begin
                  state_d = WAIT_HI;
                  tmr_ld  = 1'b1;
                  tmr_val = TO_LD;
               end
            end
            WAIT_HI: begin
               if (tmr_zero) begin
                  err_to_d = 1'b1;
                  state_d  = IDLE;
               end else if (pd_q) begin
                  sdone_d = sdone_q + STEP_W'(1);
                  for (int i = 0; i < NUM_CNT; i++) begin
                     if (cnt_q == CNTSEL_W'(i)) begin
                        if (updn_q) pos_d[i] = (pos_q[i] == POS_MAX) ? '0 : pos_q[i] + POS_W'(1);
                        else        pos_d[i] = (pos_q[i] == '0) ? POS_MAX : pos_q[i] - POS_W'(1);
                     end
                  end
                  if (SETTLE_CYC > 0) begin
                     state_d = SETTLE;
                     tmr_ld  = 1'b1;
                     tmr_val = ST_LD;
                  end else if (sdone_d == steps_q) begin
                     state_d = DONE;
                  end else begin
                     state_d = PULSE;
                     tmr_ld  = 1'b1;
                  end
               end
            end
            SETTLE: if (tmr_zero) begin
               if (sdone_q == steps_q) begin
                  state_d = DONE;
               end else begin
                  state_d = PULSE;
                  tmr_ld  = 1'b1;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge scanclk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         updn_q   <= 1'b0;
         steps_q  <= '0;
         sdone_q  <= '0;
         pos_q    <= '0;
         pd_q     <= 1'b1;
         err_to_q <= 1'b0;
         err_ul_q <= 1'b0;
         err_rg_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         updn_q   <= updn_d;
         steps_q  <= steps_d;
         sdone_q  <= sdone_d;
         pos_q    <= pos_d;
         pd_q     <= pll_phase_done_i;
         err_to_q <= err_to_d;
         err_ul_q <= err_ul_d;
         err_rg_q <= err_rg_d;
      end
   end

   // phase_en is gated combinationally so neither lock loss nor rst can leave a partial pulse.
   assign pll_phase_en_o = (state_q == PULSE) & pll_locked_i & ~rst_i;
   assign pll_updn_o     = updn_q;
   assign pll_cntsel_o   = cnt_q;
   assign req_ready_o    = (state_q == IDLE) & pll_locked_i;
   assign busy_o         = (state_q != IDLE);
   assign done_o         = (state_q == DONE);
   assign err_timeout_o  = err_to_q;
   assign err_unlock_o   = err_ul_q;
   assign err_range_o    = err_rg_q;
   assign steps_done_o   = sdone_q;

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_pos
      assign phase_pos_o[g*POS_W +: POS_W] = pos_q[g];
   end
endmodule

// File: tb/tb_gbt_rx_frameclk_dps_ctrl.sv
// Self-checking bench: reactive PLL phase_done model plus a modular-arithmetic position model.
module tb_gbt_rx_frameclk_dps_ctrl;
   localparam int NC = 2, SW = 8, SPP = 144, PEW = 2, SETC = 4, TOC = 1023, PW = 8;

   logic            scanclk = 1'b0;
   logic            rst = 1'b1, pll_locked = 1'b1, req_valid = 1'b0, req_updn = 1'b0;
   logic [4:0]      req_cnt = '0;
   logic [SW-1:0]   req_steps = '0;
   logic            req_ready, pll_phase_en, pll_updn, busy, done, err_timeout, err_unlock, err_range;
   logic [4:0]      pll_cntsel;
   logic            pll_phase_done;
   logic [SW-1:0]   steps_done;
   logic [NC*PW-1:0] phase_pos;

   int errors = 0, checks = 0;
   int pos_m [NC];
   int pll_gen = 1, seen_gen = 0, pll_t = -1;
   bit pll_mode = 1'b0, pe_prev = 1'b0;

   always #5 scanclk = ~scanclk;

   gbt_rx_frameclk_dps_ctrl #(.NUM_CNT(NC), .STEP_W(SW), .STEPS_PER_PER(SPP), .PE_WIDTH(PEW),
                              .SETTLE_CYC(SETC), .TIMEOUT_CYC(TOC)) dut (
      .scanclk_i(scanclk), .rst_i(rst), .pll_locked_i(pll_locked), .req_valid_i(req_valid),
      .req_ready_o(req_ready), .req_cnt_i(req_cnt), .req_updn_i(req_updn), .req_steps_i(req_steps),
      .pll_phase_en_o(pll_phase_en), .pll_updn_o(pll_updn), .pll_cntsel_o(pll_cntsel),
      .pll_phase_done_i(pll_phase_done), .busy_o(busy), .done_o(done), .err_timeout_o(err_timeout),
      .err_unlock_o(err_unlock), .err_range_o(err_range), .steps_done_o(steps_done),
      .phase_pos_o(phase_pos));

   // PLL model: phase_done falls 2 cycles after phase_en rises and returns 5 cycles later.
   initial forever begin
      @(negedge scanclk);
      if (pll_gen != seen_gen) begin
         seen_gen = pll_gen; pll_t = -1; pll_phase_done = 1'b1;
      end else begin
         if (pll_phase_en && !pe_prev) pll_t = 0;
         else if (pll_t >= 0) pll_t++;
         if (!pll_mode && pll_t == 2) pll_phase_done = 1'b0;
         if (pll_t == 7) begin pll_phase_done = 1'b1; pll_t = -1; end
      end
      pe_prev = pll_phase_en;
   end

   function automatic int pos_of(input int i);
      return int'(phase_pos[i*PW +: PW]);
   endfunction

   function automatic void model_apply(input int c, input bit up, input int n);
      pos_m[c] = ((pos_m[c] + (up ? n : -n)) % SPP + SPP) % SPP;
   endfunction

   task automatic tick();
      @(posedge scanclk); #1;
   endtask

   // Drives a request; returns 1 time unit into cycle T+1.
   task automatic send_req(input logic [4:0] c, input logic u, input logic [SW-1:0] n);
      req_valid = 1'b1; req_cnt = c; req_updn = u; req_steps = n;
      tick();
      req_valid = 1'b0;
   endtask

   // Follows a request from cycle T+1 until it ends, then watches a few more cycles.
   task automatic wait_end(input int budget, output int pulses, output int dones, output bit ended);
      bit prev = 1'b0;
      int extra = -1;
      pulses = 0; dones = 0; ended = 1'b0;
      for (int k = 0; k < budget && extra != 0; k++) begin
         if (pll_phase_en && !prev) pulses++;
         prev = pll_phase_en;
         if (done) dones++;
         if (!ended && (done || err_timeout || err_unlock)) begin ended = 1'b1; extra = 3; end
         else if (extra > 0) extra--;
         tick();
      end
   endtask

   task automatic test_reset();
      pll_locked = 1'b0; tick();
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_unlocked got=%b exp=0", req_ready); end
      pll_locked = 1'b1; #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_locked got=%b exp=1", req_ready); end
      checks++;
      if ({busy, done, pll_phase_en, err_timeout, err_unlock, err_range, pll_updn} !== 7'b0 ||
          steps_done !== '0 || pll_cntsel !== '0 || phase_pos !== '0) begin
         errors++;
         $display("FAIL rst_outputs got busy=%b done=%b pe=%b errs=%b%b%b sd=%0d pos=%h exp all 0",
                  busy, done, pll_phase_en, err_timeout, err_unlock, err_range, steps_done, phase_pos);
      end
      rst = 1'b0; tick(); tick();
   endtask

   task automatic test_single_step();
      int p, d; bit e;
      send_req(5'd0, 1'b1, 8'd1);
      checks++; if (pll_phase_en !== 1'b1) begin errors++; $display("FAIL single_pe_t1 got=%b exp=1", pll_phase_en); end
      checks++; if (pll_cntsel !== 5'd0 || pll_updn !== 1'b1) begin errors++; $display("FAIL single_sel got=%0d/%b exp=0/1", pll_cntsel, pll_updn); end
      tick();
      checks++; if (pll_phase_en !== 1'b1) begin errors++; $display("FAIL single_pe_t2 got=%b exp=1", pll_phase_en); end
      tick();
      checks++; if (pll_phase_en !== 1'b0) begin errors++; $display("FAIL single_pe_t3 got=%b exp=0", pll_phase_en); end
      wait_end(200, p, d, e);
      model_apply(0, 1'b1, 1);
      checks++; if (d !== 1 || p !== 0) begin errors++; $display("FAIL single_done got dones=%0d extra_pulses=%0d exp 1/0", d, p); end
      checks++; if (pos_of(0) !== 1 || steps_done !== 8'd1) begin errors++; $display("FAIL single_pos got pos=%0d sd=%0d exp 1/1", pos_of(0), steps_done); end
      checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL single_idle got busy=%b rdy=%b exp 0/1", busy, req_ready); end
   endtask

   task automatic test_wrap();
      int p, d; bit e;
      send_req(5'd0, 1'b0, 8'd2);
      wait_end(400, p, d, e); model_apply(0, 1'b0, 2);
      checks++; if (pos_of(0) !== pos_m[0] || pos_m[0] != SPP-1) begin errors++; $display("FAIL wrap_pre got=%0d exp=%0d", pos_of(0), SPP-1); end
      send_req(5'd0, 1'b1, 8'd3);
      wait_end(400, p, d, e); model_apply(0, 1'b1, 3);
      checks++; if (p !== 3 || d !== 1) begin errors++; $display("FAIL wrap_up_pulses got=%0d/%0d exp 3/1", p, d); end
      checks++; if (pos_of(0) !== 2) begin errors++; $display("FAIL wrap_up_pos got=%0d exp=2", pos_of(0)); end
      send_req(5'd0, 1'b0, 8'd3);
      wait_end(400, p, d, e); model_apply(0, 1'b0, 3);
      checks++; if (p !== 3 || d !== 1) begin errors++; $display("FAIL wrap_dn_pulses got=%0d/%0d exp 3/1", p, d); end
      checks++; if (pos_of(0) !== SPP-1 || steps_done !== 8'd3) begin errors++; $display("FAIL wrap_dn_pos got=%0d sd=%0d exp=%0d/3", pos_of(0), steps_done, SPP-1); end
   endtask

   task automatic test_zero_range();
      send_req(5'd1, 1'b1, 8'd0);
      checks++; if (done !== 1'b1 || pll_phase_en !== 1'b0) begin errors++; $display("FAIL zero_done got done=%b pe=%b exp 1/0", done, pll_phase_en); end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after got done=%b busy=%b exp 0/0", done, busy); end
      send_req(5'd5, 1'b1, 8'd4);
      checks++; if (err_range !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL range got err=%b busy=%b exp 1/0", err_range, busy); end
      tick();
      checks++; if (err_range !== 1'b0 || busy !== 1'b0 || pll_phase_en !== 1'b0) begin errors++; $display("FAIL range_after got err=%b busy=%b pe=%b exp 0/0/0", err_range, busy, pll_phase_en); end
      for (int i = 0; i < NC; i++) begin
         checks++; if (pos_of(i) !== pos_m[i]) begin errors++; $display("FAIL range_pos%0d got=%0d exp=%0d", i, pos_of(i), pos_m[i]); end
      end
   endtask

   task automatic test_timeout();
      int first = -1, hits = 0; bit rdy_next = 1'b0;
      pll_mode = 1'b1;
      send_req(5'd1, 1'b1, 8'd2);
      for (int k = 1; k <= TOC + 40; k++) begin
         if (err_timeout) begin hits++; if (first < 0) first = k; end
         if (first > 0 && k == first + 1) rdy_next = req_ready;
         tick();
      end
      pll_mode = 1'b0; pll_gen++;
      checks++; if (first !== TOC + PEW + 1 || hits !== 1) begin errors++; $display("FAIL timeout_when got=%0d hits=%0d exp=%0d/1", first, hits, TOC + PEW + 1); end
      checks++; if (rdy_next !== 1'b1) begin errors++; $display("FAIL timeout_ready got=%b exp=1", rdy_next); end
      checks++; if (pos_of(1) !== pos_m[1] || steps_done !== 8'd0) begin errors++; $display("FAIL timeout_pos got=%0d sd=%0d exp=%0d/0", pos_of(1), steps_done, pos_m[1]); end
      tick();
   endtask

   task automatic test_unlock();
      int p = 0, k = 0; bit prev = 1'b0;
      send_req(5'd1, 1'b1, 8'd10);
      while (k < 400 && p < 4) begin
         if (pll_phase_en && !prev) p++;
         prev = pll_phase_en;
         if (p < 4) begin tick(); k++; end
      end
      checks++; if (p !== 4) begin errors++; $display("FAIL unlock_reach got pulses=%0d exp=4", p); end
      pll_locked = 1'b0; #1;
      checks++; if (pll_phase_en !== 1'b0) begin errors++; $display("FAIL unlock_pe got=%b exp=0", pll_phase_en); end
      @(posedge scanclk); #1;
      model_apply(1, 1'b1, 3);
      checks++; if (err_unlock !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL unlock_err got=%b busy=%b exp 1/0", err_unlock, busy); end
      checks++; if (steps_done !== 8'd3 || pos_of(1) !== pos_m[1]) begin errors++; $display("FAIL unlock_pos got sd=%0d pos=%0d exp 3/%0d", steps_done, pos_of(1), pos_m[1]); end
      pll_locked = 1'b1; pll_gen++; tick();
      checks++; if (err_unlock !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL unlock_after got err=%b rdy=%b exp 0/1", err_unlock, req_ready); end
      tick();
   endtask

   task automatic test_random();
      int p, d; bit e;
      logic [4:0] c; logic u; logic [SW-1:0] n;
      for (int it = 0; it < 12; it++) begin
         c = 5'($urandom_range(0, NC)); u = 1'($urandom_range(0, 1)); n = SW'($urandom_range(0, 5));
         checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready got=%b exp=1", it, req_ready); end
         send_req(c, u, n);
         if (int'(c) >= NC) begin
            checks++; if (err_range !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_range got=%b/%b exp 1/0", it, err_range, busy); end
         end else if (n == 0) begin
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL rnd%0d_zero got=%b exp=1", it, done); end
         end else begin
            wait_end(600, p, d, e);
            model_apply(int'(c), u, int'(n));
            checks++; if (p !== int'(n) || d !== 1 || steps_done !== n) begin errors++; $display("FAIL rnd%0d_steps got p=%0d d=%0d sd=%0d exp %0d/1/%0d", it, p, d, steps_done, n, n); end
         end
         tick(); tick();
         for (int i = 0; i < NC; i++) begin
            checks++; if (pos_of(i) !== pos_m[i]) begin errors++; $display("FAIL rnd%0d_pos%0d got=%0d exp=%0d", it, i, pos_of(i), pos_m[i]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int p = 0, k = 0, pe_after = 0; bit prev = 1'b0;
      send_req(5'd0, 1'b1, 8'd5);
      while (k < 400 && p < 2) begin
         if (pll_phase_en && !prev) p++;
         prev = pll_phase_en;
         if (p < 2) begin tick(); k++; end
      end
      repeat (6) tick();
      checks++; if (busy !== 1'b1 || p !== 2) begin errors++; $display("FAIL rmid_busy got=%b pulses=%0d exp 1/2", busy, p); end
      rst = 1'b1; tick();
      for (int i = 0; i < NC; i++) pos_m[i] = 0;
      checks++;
      if ({busy, done, pll_phase_en, err_timeout, err_unlock, err_range, pll_updn} !== 7'b0 ||
          steps_done !== '0 || pll_cntsel !== '0 || phase_pos !== '0) begin
         errors++;
         $display("FAIL rmid_outputs got busy=%b pe=%b sd=%0d pos=%h exp all 0", busy, pll_phase_en, steps_done, phase_pos);
      end
      rst = 1'b0; pll_gen++;
      repeat (40) begin if (pll_phase_en) pe_after++; tick(); end
      checks++; if (pe_after !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_quiet got pe=%0d busy=%b exp 0/0", pe_after, busy); end
   endtask

   initial begin
      for (int i = 0; i < NC; i++) pos_m[i] = 0;
      test_reset();
      test_single_step();
      test_wrap();
      test_zero_range();
      test_timeout();
      test_unlock();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
